pipeline_hazard_ctrl: RTL

Parametrised hazard and stall controller for the 5-stage MIPS pipeline, generalising the current free-running pipeline so that fetch, decode and execute can stall and be flushed. It generates forwarding selects for the execute and decode stages, detects load-use and branch-operand hazards, and sequences a multi-cycle execute operation through a small state machine. It also keeps saturating stall and flush event counters for the debug display. It sits beside the pipeline registers and drives their stall and flush inputs.

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 24 ++
 rtl/pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
//   - Forwarding mux select encodings used by the execute-stage operand muxes.
//   - Multi-cycle execute FSM state encodings.
//   - fwdSelect: resolves memory/writeback matches into an execute operand select.
package pipeline_pkg;

  // Execute-stage operand select encodings
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB   = 2'b01;  // result from writeback stage
  localparam logic [1:0] FWD_MEM  = 2'b10;  // ALU result from memory stage

  // Multi-cycle execute FSM states
  localparam logic [0:0] MC_IDLE = 1'b0;
  localparam logic [0:0] MC_BUSY = 1'b1;

  // The memory stage holds the younger producer, so it wins over writeback.
  function automatic logic [1:0] fwdSelect(input logic memMatch, input logic wbMatch);
    if (memMatch) begin
      return FWD_MEM;
    end
    if (wbMatch) begin
      return FWD_WB;
    end
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter for debug event statistics.
// Ports:
//   Clk    in  1  clock
//   clear  in  1  synchronous clear, takes priority over incEn
//   incEn  in  1  count one event this cycle
//   count  out W  current value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         clear,
  input  logic         incEn,
  output logic [W-1:0] count
);

  always_ff @(posedge Clk) begin
    if (clear) begin
      count <= '0;
    end else if (incEn && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard detection, forwarding selects and stall/flush
// sequencing for the 5-stage pipeline, plus a small FSM that holds execute
// for multi-cycle operations and two saturating debug counters.
//
// Parameters:
//   REG_AW  register address width
//   MC_LAT  execute occupancy of a multi-cycle op in cycles (>=1, 1 disables FSM)
//   CNT_W   event counter width
//
// Ports:
//   Clk, Reset                          clock, synchronous active-high reset
//   RsD, RtD                            decode source registers
//   RsE, RtE                            execute source registers
//   WriteRegE/M/W, RegWriteE/M/W        destination register and write enable per stage
//   MemToRegE, MemToRegM                a load sits in that stage
//   BranchD, PCSrcD                     branch compare in decode, redirect request
//   MultiCycleE                         the op in execute is multi-cycle
//   StallF/D/E                          hold pipeline registers
//   FlushD/E/M                          insert bubble into pipeline registers
//   ForwardAE/BE                        execute operand selects (FWD_*)
//   ForwardAD/BD                        decode branch operand select from memory stage
//   StallCycles, FlushEvents            saturating debug counters
//
// Multi-cycle FSM:
//   state   | meaning
//   MC_IDLE | no multi-cycle op held; a new one stalls and loads Cnt=MC_LAT-2
//   MC_BUSY | op held in execute; stall while Cnt>0, release when Cnt==0
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemToRegE,
  input  logic              MemToRegM,
  input  logic              BranchD,
  input  logic              PCSrcD,
  input  logic              MultiCycleE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  FlushEvents
);

  // Down-counter sized for the largest load value MC_LAT-2.
  localparam int CntW       = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam int CntLoadInt = (MC_LAT > 1) ? (MC_LAT - 2) : 0;
  localparam logic [CntW-1:0] CntLoad = CntW'(CntLoadInt);
  localparam bit McEnable   = (MC_LAT > 1);

  // A stage matches a source when it writes a non-zero register equal to it.
  function automatic logic regMatch(input logic we, input logic [REG_AW-1:0] wr,
                                    input logic [REG_AW-1:0] src);
    return we && (wr != '0) && (wr == src);
  endfunction

  logic            mcState;
  logic            mcStateNext;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cntNext;
  logic            mcStall;

  logic matchERsD, matchERtD;
  logic matchMRsD, matchMRtD;
  logic matchMRsE, matchMRtE;
  logic matchWRsE, matchWRtE;
  logic luStall;
  logic brStall;
  logic anyStall;

  assign matchERsD = regMatch(RegWriteE, WriteRegE, RsD);
  assign matchERtD = regMatch(RegWriteE, WriteRegE, RtD);
  assign matchMRsD = regMatch(RegWriteM, WriteRegM, RsD);
  assign matchMRtD = regMatch(RegWriteM, WriteRegM, RtD);
  assign matchMRsE = regMatch(RegWriteM, WriteRegM, RsE);
  assign matchMRtE = regMatch(RegWriteM, WriteRegM, RtE);
  assign matchWRsE = regMatch(RegWriteW, WriteRegW, RsE);
  assign matchWRtE = regMatch(RegWriteW, WriteRegW, RtE);

  // Load result is not available until after memory, so decode must wait.
  assign luStall = MemToRegE && (matchERsD || matchERtD);

  // Branch compare in decode can only take operands forwarded from memory:
  // anything still in execute, or a load still in memory, is too late.
  assign brStall = BranchD && (matchERsD || matchERtD ||
                               (MemToRegM && (matchMRsD || matchMRtD)));

  always_comb begin
    mcStall     = 1'b0;
    mcStateNext = mcState;
    cntNext     = cnt;
    case (mcState)
      MC_IDLE: begin
        if (McEnable && MultiCycleE) begin
          mcStall     = 1'b1;
          cntNext     = CntLoad;
          mcStateNext = MC_BUSY;
        end
      end
      MC_BUSY: begin
        // Terminal count: release execute; MultiCycleE belongs to this op, so
        // it is not allowed to retrigger on the same edge.
        if (cnt != '0) begin
          mcStall = 1'b1;
          cntNext = cnt - 1'b1;
        end else begin
          mcStateNext = MC_IDLE;
        end
      end
      default: begin
        mcStateNext = MC_IDLE;
        cntNext     = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcState <= MC_IDLE;
      cnt     <= '0;
    end else begin
      mcState <= mcStateNext;
      cnt     <= cntNext;
    end
  end

  assign anyStall = mcStall || luStall || brStall;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushM    = 1'b1;
    ForwardAE = FWD_NONE;
    ForwardBE = FWD_NONE;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (!Reset) begin
      StallE    = mcStall;
      StallF    = anyStall;
      StallD    = anyStall;
      FlushM    = mcStall;
      // When execute is held the op there must survive, so no bubble.
      FlushE    = (luStall || brStall) && !mcStall;
      // A redirect from a stalled decode uses operands that are not ready yet.
      FlushD    = PCSrcD && !anyStall;
      ForwardAE = fwdSelect(matchMRsE, matchWRsE);
      ForwardBE = fwdSelect(matchMRtE, matchWRtE);
      ForwardAD = matchMRsD;
      ForwardBD = matchMRtD;
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .Clk   (Clk),
    .clear (Reset),
    .incEn (StallD),
    .count (StallCycles)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .Clk   (Clk),
    .clear (Reset),
    .incEn (FlushD),
    .count (FlushEvents)
  );

endmodule
